// File: rtl/p2p_reg_pkg.sv
// Shared constants for the point-to-point register file.
package p2p_reg_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 12;
   localparam int DEFAULT_DATA_WIDTH = 32;

endpackage : p2p_reg_pkg

// File: rtl/register_file_mem.sv
// Storage array: one read/write port (a) and one read-only port (b), both
// synchronous and read-first, with resettable read-data latches (block RAM style).
module register_file_mem
   import p2p_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rdata_rst,
   input  logic                  a_en,
   input  logic                  a_we,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_en,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic [DATA_WIDTH-1:0] b_rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Declaration initialiser gives the all-zero power-up contents; reset never clears it.
   logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};
   logic [DATA_WIDTH-1:0] a_rdata_r;
   logic [DATA_WIDTH-1:0] b_rdata_r;

   // Port a write.
   always_ff @(posedge clk) begin
      if (a_en && a_we) begin
         mem_r[a_addr] <= a_wdata;
      end
   end

   // Port a read latch; sampling before the write lands makes it read-first.
   always_ff @(posedge clk) begin
      if (rdata_rst) begin
         a_rdata_r <= '0;
      end else if (a_en) begin
         a_rdata_r <= mem_r[a_addr];
      end
   end

   // Port b read latch.
   always_ff @(posedge clk) begin
      if (rdata_rst) begin
         b_rdata_r <= '0;
      end else if (b_en) begin
         b_rdata_r <= mem_r[b_addr];
      end
   end

   assign a_rdata = a_rdata_r;
   assign b_rdata = b_rdata_r;

endmodule : register_file_mem

// File: rtl/register_file.sv
// Register file with a read/write system port and a read-only internal port.
// Qualifies the port enables, blocks all accesses during reset, clears outputs on reset.
module register_file
   import p2p_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  system_reg_en,
   input  logic                  system_reg_we,
   input  logic [ADDR_WIDTH-1:0] system_reg_addr,
   input  logic [DATA_WIDTH-1:0] system_reg_din,
   output logic [DATA_WIDTH-1:0] system_reg_dout,
   input  logic                  internal_read,
   input  logic [ADDR_WIDTH-1:0] internal_reg_addr,
   output logic [DATA_WIDTH-1:0] internal_reg_out
);

   logic sys_en_s;
   logic sys_we_s;
   logic int_en_s;

   // Enable qualification; reset discards reads and suppresses writes.
   always_comb begin
      sys_en_s = 1'b0;
      sys_we_s = 1'b0;
      int_en_s = 1'b0;
      if (rst) begin
         sys_en_s = 1'b0;
         sys_we_s = 1'b0;
         int_en_s = 1'b0;
      end else begin
         sys_en_s = system_reg_en;
         sys_we_s = system_reg_en & system_reg_we;
         int_en_s = internal_read;
      end
   end

   register_file_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk       (clk),
      .rdata_rst (rst),
      .a_en      (sys_en_s),
      .a_we      (sys_we_s),
      .a_addr    (system_reg_addr),
      .a_wdata   (system_reg_din),
      .a_rdata   (system_reg_dout),
      .b_en      (int_en_s),
      .b_addr    (internal_reg_addr),
      .b_rdata   (internal_reg_out)
   );

endmodule : register_file

// File: tb/tb_register_file.sv
// Directed plus randomized bench for register_file against an array-based reference.
module tb_register_file;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 2 ** AW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          system_reg_en = 1'b0;
   logic          system_reg_we = 1'b0;
   logic [AW-1:0] system_reg_addr = '0;
   logic [DW-1:0] system_reg_din = '0;
   logic [DW-1:0] system_reg_dout;
   logic          internal_read = 1'b0;
   logic [AW-1:0] internal_reg_addr = '0;
   logic [DW-1:0] internal_reg_out;

   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] exp_sys;
   logic [DW-1:0] exp_int;
   int            checks = 0;
   int            passed = 0;

   register_file #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk               (clk),
      .rst               (rst),
      .system_reg_en     (system_reg_en),
      .system_reg_we     (system_reg_we),
      .system_reg_addr   (system_reg_addr),
      .system_reg_din    (system_reg_din),
      .system_reg_dout   (system_reg_dout),
      .internal_read     (internal_read),
      .internal_reg_addr (internal_reg_addr),
      .internal_reg_out  (internal_reg_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
   endtask

   // One clock of stimulus; the reference updates at the edge, outputs compared 1 time unit later.
   task automatic step(input string tag, input logic r, input logic en, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic ird, input logic [AW-1:0] ia);
      @(negedge clk);
      rst = r; system_reg_en = en; system_reg_we = we;
      system_reg_addr = a; system_reg_din = d;
      internal_read = ird; internal_reg_addr = ia;
      @(posedge clk);
      if (r) begin
         exp_sys = '0;
         exp_int = '0;
      end else begin
         if (en)  exp_sys = ref_mem[a];
         if (ird) exp_int = ref_mem[ia];
         if (en && we) ref_mem[a] = d;
      end
      #1;
      check({tag, ".sys"}, system_reg_dout, exp_sys);
      check({tag, ".int"}, internal_reg_out, exp_int);
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 5))
         0:       pick_addr = 12'hBEE;
         1:       pick_addr = 12'h000;
         2:       pick_addr = 12'hFFF;
         3:       pick_addr = 12'h001;
         default: pick_addr = AW'($urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      exp_sys = '0;
      exp_int = '0;

      // Reset clears both outputs.
      step("reset", 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      check("reset_sys_zero", system_reg_dout, 32'h0000_0000);
      check("reset_int_zero", internal_reg_out, 32'h0000_0000);

      // Internal read of an unwritten word returns zero.
      step("int_rd_bee", 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'hBEE);
      check("int_rd_bee_zero", internal_reg_out, 32'h0000_0000);

      // Write is read-first, then the new value reads back.
      step("wr_bee", 1'b0, 1'b1, 1'b1, 12'hBEE, 32'h0000_0BEE, 1'b0, 12'h000);
      check("wr_bee_old", system_reg_dout, 32'h0000_0000);
      step("rd_bee", 1'b0, 1'b1, 1'b0, 12'hBEE, 32'h0, 1'b0, 12'h000);
      check("rd_bee_new", system_reg_dout, 32'h0000_0BEE);

      // Both ports read the same word in one cycle.
      step("dual_rd", 1'b0, 1'b1, 1'b0, 12'hBEE, 32'h0, 1'b1, 12'hBEE);
      check("dual_rd_sys", system_reg_dout, 32'h0000_0BEE);
      check("dual_rd_int", internal_reg_out, 32'h0000_0BEE);

      // Write collides with internal read: internal sees old data.
      step("collide", 1'b0, 1'b1, 1'b1, 12'hBEE, 32'hFFFF_FFFF, 1'b1, 12'hBEE);
      check("collide_int_old", internal_reg_out, 32'h0000_0BEE);
      step("collide_next", 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'hBEE);
      check("collide_int_new", internal_reg_out, 32'hFFFF_FFFF);

      // Reset with a write attempted: outputs zero, storage untouched.
      step("rst_wr", 1'b1, 1'b1, 1'b1, 12'hBEE, 32'h1111_2222, 1'b1, 12'hBEE);
      check("rst_wr_sys", system_reg_dout, 32'h0000_0000);
      check("rst_wr_int", internal_reg_out, 32'h0000_0000);
      step("post_rst", 1'b0, 1'b1, 1'b0, 12'hBEE, 32'h0, 1'b1, 12'hBEE);
      check("post_rst_sys", system_reg_dout, 32'hFFFF_FFFF);
      check("post_rst_int", internal_reg_out, 32'hFFFF_FFFF);

      // We without en has no effect and dout holds.
      step("we_only", 1'b0, 1'b0, 1'b1, 12'h000, 32'h1234_5678, 1'b0, 12'h000);
      check("we_only_hold", system_reg_dout, 32'hFFFF_FFFF);
      step("we_only_hold2", 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000);
      check("we_only_hold2", system_reg_dout, 32'hFFFF_FFFF);
      step("rd_000", 1'b0, 1'b1, 1'b0, 12'h000, 32'h0, 1'b1, 12'h000);
      check("rd_000_sys", system_reg_dout, 32'h0000_0000);
      check("rd_000_int", internal_reg_out, 32'h0000_0000);

      // Top-of-range address.
      step("wr_fff", 1'b0, 1'b1, 1'b1, 12'hFFF, 32'hA5A5_5A5A, 1'b0, 12'h000);
      step("rd_fff", 1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'hFFF);
      check("rd_fff_int", internal_reg_out, 32'hA5A5_5A5A);

      // Randomized traffic against the reference.
      for (int n = 0; n < 600; n++) begin
         step("rand",
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 1) == 1),
              pick_addr(),
              DW'($urandom()),
              ($urandom_range(0, 2) != 0),
              pick_addr());
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12, word-address width; depth = 2^ADDR_WIDTH words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register word width.
REQ-003 The block SHALL have port clk, input, 1 bit, the only clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; one clock, synchronous, active-high.
REQ-005 The block SHALL have port system_reg_en, input, 1 bit, system port access enable.
REQ-006 The block SHALL have port system_reg_we, input, 1 bit, system port write enable; qualified by system_reg_en.
REQ-007 The block SHALL have port system_reg_addr, input, ADDR_WIDTH bits, system port word address.
REQ-008 The block SHALL have port system_reg_din, input, DATA_WIDTH bits, system port write data.
REQ-009 The block SHALL have port system_reg_dout, output, DATA_WIDTH bits, system port read data.
REQ-010 The block SHALL have port internal_read, input, 1 bit, internal port read strobe.
REQ-011 The block SHALL have port internal_reg_addr, input, ADDR_WIDTH bits, internal port word address.
REQ-012 The block SHALL have port internal_reg_out, output, DATA_WIDTH bits, internal port read data.

Function
REQ-013 Storage SHALL be 2^ADDR_WIDTH words of DATA_WIDTH bits; every word is zero at power-up.
REQ-014 A system write SHALL occur at a rising edge with system_reg_en=1 and system_reg_we=1, storing system_reg_din at system_reg_addr.
REQ-015 A system read SHALL occur at a rising edge with system_reg_en=1; system_reg_dout SHALL show the addressed word after that edge (1-cycle latency).
REQ-016 On a system write, system_reg_dout SHALL be read-first: it shows the word's old contents; the new value is readable from the next access.
REQ-017 With system_reg_en=0, storage SHALL not change and system_reg_dout SHALL hold its last value; system_reg_we alone SHALL have no effect.
REQ-018 An internal read SHALL occur at a rising edge with internal_read=1; internal_reg_out SHALL show the addressed word after that edge (1-cycle latency).
REQ-019 With internal_read=0, internal_reg_out SHALL hold its last value.
REQ-020 The internal port SHALL be read-only and SHALL never modify storage.
REQ-021 Both ports SHALL operate independently in the same cycle, including on the same address.
REQ-022 If a system write and an internal read target the same address in the same cycle, internal_reg_out SHALL return the old contents.
REQ-023 Addresses SHALL be word addresses over the full range 0 to 2^ADDR_WIDTH-1, with no wrap or out-of-range case.
REQ-024 No handshake or backpressure SHALL exist; every enabled access completes in one cycle.

Reset
REQ-025 While rst=1 at a rising edge, system_reg_dout and internal_reg_out SHALL be 0.
REQ-026 While rst=1, writes SHALL be ignored; storage contents SHALL be preserved through reset (not cleared).
REQ-027 Reads enabled in the cycle rst is asserted SHALL be discarded; accesses SHALL resume normally on the first edge after rst deasserts.

Structure
REQ-028 The package p2p_reg_pkg SHALL hold the default ADDR_WIDTH and DATA_WIDTH constants.
REQ-029 Storage SHALL be one sub-module, register_file_mem: one read/write port and one read-only port, both synchronous, read-first, and inferable as block RAM.
REQ-030 The top-level SHALL contain only the enable qualification, reset gating of writes, and output registers and their reset.

Verification
REQ-031 After reset, internal_read=1, addr 0xBEE -> internal_reg_out=0x00000000 one cycle later.
REQ-032 en=1, we=1, addr 0xBEE, din 0x00000BEE -> system_reg_dout is the old value 0; then en=1, we=0 -> system_reg_dout=0x00000BEE.
REQ-033 Same-cycle system read and internal read of 0xBEE -> both outputs =0x00000BEE.
REQ-034 System write 0xFFFFFFFF to 0xBEE with internal read of 0xBEE in the same cycle -> internal_reg_out=0x00000BEE; next internal read -> 0xFFFFFFFF.
REQ-035 Assert rst after the writes above -> both outputs 0; a read of 0xBEE after reset -> 0xFFFFFFFF; a write attempted during reset -> no change.
REQ-036 With en=0 and we=1, din 0x12345678 to 0x000 -> a later read of 0x000 returns 0 and system_reg_dout holds its value while en=0.
